codificador_botoes: RTL and testbench



---
 rtl/codificador_botoes_pkg.sv | 15 +
 rtl/codificador_botoes_sincronizador_2ff.sv | 24 ++
 rtl/codificador_botoes.sv | 140 ++++++++++++++
 tb/tb_codificador_botoes.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/codificador_botoes_pkg.sv
// Shared definitions for the push-button encoder: FSM state encodings and
// the default debounce length.
package codificador_botoes_pkg;

    localparam int DEBOUNCE_PADRAO = 50000;

    typedef enum logic [2:0] {
        ESPERA = 3'd0,
        FILTRO = 3'd1,
        SEGURA = 3'd2,
        ERRO   = 3'd3,
        SOLTA  = 3'd4
    } estado_t;

endpackage

// File: rtl/codificador_botoes_sincronizador_2ff.sv
// Parameterized-width two-flop synchronizer for pin-facing inputs,
// asynchronous active-high reset.
module sincronizador_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dado,
    output logic [WIDTH-1:0] sinc
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            sinc <= '0;
        end else begin
            meta <= dado;
            sinc <= meta;
        end
    end

endmodule

// File: rtl/codificador_botoes.sv
// Debounces the eight player buttons and reports a single accepted press as a
// registered one-hot code, its binary index and a one-cycle strobe.
module codificador_botoes
    import codificador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] botoes,
    output logic [7:0] codigo,
    output logic [2:0] indice,
    output logic       jogada_feita,
    output logic       erro_multiplo
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [2:0] onehot_to_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    logic [7:0]       sinc;
    estado_t          estado, estado_next;
    logic [7:0]       amostra, amostra_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [7:0]       codigo_next;
    logic [2:0]       indice_next;
    logic             jogada_next;
    logic             erro_next;

    sincronizador_2ff #(.WIDTH(8)) u_sinc (
        .clock (clock),
        .reset (reset),
        .dado  (botoes),
        .sinc  (sinc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= ESPERA;
            amostra       <= '0;
            cnt           <= '0;
            codigo        <= '0;
            indice        <= '0;
            jogada_feita  <= 1'b0;
            erro_multiplo <= 1'b0;
        end else begin
            estado        <= estado_next;
            amostra       <= amostra_next;
            cnt           <= cnt_next;
            codigo        <= codigo_next;
            indice        <= indice_next;
            jogada_feita  <= jogada_next;
            erro_multiplo <= erro_next;
        end
    end

    // A press is accepted only after the same pattern has been seen for
    // DEBOUNCE_CYCLES cycles; release needs the same stability before re-arming.
    always_comb begin
        estado_next  = estado;
        amostra_next = amostra;
        cnt_next     = cnt;
        codigo_next  = codigo;
        indice_next  = indice;
        jogada_next  = 1'b0;
        erro_next    = erro_multiplo;
        case (estado)
            ESPERA: begin
                if (sinc != 8'h00) begin
                    amostra_next = sinc;
                    cnt_next     = '0;
                    estado_next  = FILTRO;
                end
            end
            FILTRO: begin
                if (sinc != amostra) begin
                    cnt_next    = '0;
                    estado_next = ESPERA;
                end else if (cnt == CNT_MAX) begin
                    if (popcount(amostra) == 4'd1) begin
                        codigo_next = amostra;
                        indice_next = onehot_to_index(amostra);
                        jogada_next = 1'b1;
                        estado_next = SEGURA;
                    end else begin
                        erro_next   = 1'b1;
                        estado_next = ERRO;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            SEGURA: begin
                if (sinc == 8'h00) begin
                    cnt_next    = '0;
                    estado_next = SOLTA;
                end
            end
            ERRO: begin
                if (sinc == 8'h00) begin
                    erro_next   = 1'b0;
                    cnt_next    = '0;
                    estado_next = SOLTA;
                end
            end
            SOLTA: begin
                if (sinc != 8'h00) begin
                    cnt_next = '0;
                end else if (cnt == CNT_MAX) begin
                    estado_next = ESPERA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                estado_next = ESPERA;
            end
        endcase
    end

endmodule

// File: tb/tb_codificador_botoes.sv
// Scoreboard bench for codificador_botoes with a short debounce window:
// expected strobes are queued when presses are driven and checked on arrival.
module tb_codificador_botoes;

    localparam int DEB = 4;

    typedef struct {
        logic [7:0] codigo;
        logic [2:0] indice;
        int         ciclo;
    } esperado_t;

    logic       clock;
    logic       reset;
    logic [7:0] botoes;
    logic [7:0] codigo;
    logic [2:0] indice;
    logic       jogada_feita;
    logic       erro_multiplo;

    esperado_t fila[$];
    int        ciclo;
    int        compared;
    int        mismatched;

    codificador_botoes #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .codigo        (codigo),
        .indice        (indice),
        .jogada_feita  (jogada_feita),
        .erro_multiplo (erro_multiplo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial ciclo = 0;
    always @(posedge clock) ciclo <= ciclo + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observado,
                               input logic [31:0] esperado);
        compared++;
        if (observado !== esperado) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observado, esperado, ciclo);
        end
    endtask

    // Drive a pattern at the falling edge and hold it for a number of rising edges.
    task automatic applyStimulus(input logic [7:0] valor, input int ciclos);
        botoes = valor;
        repeat (ciclos) @(negedge clock);
    endtask

    // The strobe appears DEB+2 edges after the first sampling edge, i.e. it is
    // visible at the falling edge DEB+3 cycles after the drive point.
    task automatic pushPress(input logic [7:0] cod, input logic [2:0] idx);
        esperado_t e;
        e.codigo = cod;
        e.indice = idx;
        e.ciclo  = ciclo + DEB + 3;
        fila.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset && jogada_feita) begin
            if (fila.size() == 0) begin
                checkOutput("pulso_inesperado", 32'd1, 32'd0);
            end else begin
                esperado_t e;
                e = fila.pop_front();
                checkOutput("pulso_codigo", {24'd0, codigo}, {24'd0, e.codigo});
                checkOutput("pulso_indice", {29'd0, indice}, {29'd0, e.indice});
                checkOutput("pulso_ciclo", ciclo, e.ciclo);
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        botoes     = 8'h00;
        repeat (3) @(negedge clock);
        checkOutput("reset_codigo", {24'd0, codigo}, 32'h00);
        checkOutput("reset_indice", {29'd0, indice}, 32'd0);
        checkOutput("reset_jogada", {31'd0, jogada_feita}, 32'd0);
        checkOutput("reset_erro", {31'd0, erro_multiplo}, 32'd0);
        reset = 1'b0;
        applyStimulus(8'h00, 3);

        // Clean press of button 5, held well past acceptance.
        pushPress(8'h20, 3'd5);
        applyStimulus(8'h20, 20);
        checkOutput("limpo_codigo", {24'd0, codigo}, 32'h20);
        checkOutput("limpo_indice", {29'd0, indice}, 32'd5);
        applyStimulus(8'h00, 12);
        checkOutput("limpo_fila", fila.size(), 32'd0);

        // Bouncing press of button 2 that finally settles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h04, 2);
            applyStimulus(8'h00, 2);
        end
        pushPress(8'h04, 3'd2);
        applyStimulus(8'h04, 15);
        checkOutput("bounce_codigo", {24'd0, codigo}, 32'h04);
        checkOutput("bounce_indice", {29'd0, indice}, 32'd2);
        applyStimulus(8'h00, 12);
        checkOutput("bounce_fila", fila.size(), 32'd0);

        // Two buttons at once: error flag, no strobe, code untouched.
        applyStimulus(8'h81, 10);
        checkOutput("multi_erro", {31'd0, erro_multiplo}, 32'd1);
        checkOutput("multi_codigo", {24'd0, codigo}, 32'h04);
        applyStimulus(8'h00, 2);
        checkOutput("multi_erro_2", {31'd0, erro_multiplo}, 32'd1);
        applyStimulus(8'h00, 1);
        checkOutput("multi_erro_3", {31'd0, erro_multiplo}, 32'd0);
        applyStimulus(8'h00, 10);

        // Re-press after too short a release must be ignored.
        pushPress(8'h01, 3'd0);
        applyStimulus(8'h01, 10);
        applyStimulus(8'h00, 2);
        applyStimulus(8'h01, 10);
        applyStimulus(8'h00, 12);
        checkOutput("curto_fila", fila.size(), 32'd0);

        // Re-press after a long enough release is accepted again.
        pushPress(8'h01, 3'd0);
        applyStimulus(8'h01, 10);
        applyStimulus(8'h00, 7);
        pushPress(8'h01, 3'd0);
        applyStimulus(8'h01, 10);
        applyStimulus(8'h00, 12);
        checkOutput("longo_fila", fila.size(), 32'd0);
        checkOutput("longo_indice", {29'd0, indice}, 32'd0);

        // Single-cycle glitch on button 4 changes nothing.
        applyStimulus(8'h10, 1);
        applyStimulus(8'h00, 12);
        checkOutput("glitch_codigo", {24'd0, codigo}, 32'h01);
        checkOutput("glitch_erro", {31'd0, erro_multiplo}, 32'd0);

        // Reset in the middle of filtering button 3 clears everything at once.
        applyStimulus(8'h08, 4);
        reset  = 1'b1;
        botoes = 8'h00;
        #1;
        checkOutput("rst_meio_codigo", {24'd0, codigo}, 32'h00);
        checkOutput("rst_meio_indice", {29'd0, indice}, 32'd0);
        checkOutput("rst_meio_jogada", {31'd0, jogada_feita}, 32'd0);
        checkOutput("rst_meio_erro", {31'd0, erro_multiplo}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        applyStimulus(8'h00, 12);
        checkOutput("rst_meio_codigo_apos", {24'd0, codigo}, 32'h00);
        checkOutput("fila_final", fila.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
